// File: rtl/icache_ctrl_pkg.sv
// Shared types and sizing for the instruction-cache controller.
package icache_ctrl_pkg;
   localparam int XLEN      = 32;
   localparam int NUM_LINES = 32;
   localparam int IDX_W     = $clog2(NUM_LINES);
   localparam int TAG_W     = XLEN - 3 - IDX_W;
   localparam int MEM_TAG_W = 4;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'd0,
      BUS_LOAD  = 2'd1,
      BUS_STORE = 2'd2
   } BUS_COMMAND;

   typedef enum logic [1:0] {
      IC_IDLE = 2'd0,
      IC_REQ  = 2'd1,
      IC_WAIT = 2'd2
   } ICACHE_STATE;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [63:0]      data;
   } ICACHE_LINE;
endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface icache_ctrl_if;
   import icache_ctrl_pkg::*;

   logic [XLEN-1:0]      proc2Icache_addr;
   logic                 invalidate_all;
   logic [63:0]          Icache2proc_data;
   logic                 Icache2proc_data_valid;
   BUS_COMMAND           proc2mem_command;
   logic [XLEN-1:0]      proc2mem_addr;
   logic                 mem_grant;
   logic [MEM_TAG_W-1:0] mem2proc_response;
   logic [63:0]          mem2proc_data;
   logic [MEM_TAG_W-1:0] mem2proc_tag;

   modport slave (
      input  proc2Icache_addr, invalidate_all, mem_grant,
             mem2proc_response, mem2proc_data, mem2proc_tag,
      output Icache2proc_data, Icache2proc_data_valid,
             proc2mem_command, proc2mem_addr
   );

   modport master (
      output proc2Icache_addr, invalidate_all, mem_grant,
             mem2proc_response, mem2proc_data, mem2proc_tag,
      input  Icache2proc_data, Icache2proc_data_valid,
             proc2mem_command, proc2mem_addr
   );
endinterface

// File: rtl/icache_line_array.sv
// Direct-mapped line storage: async read, one write port, global invalidate.
module icache_line_array
   import icache_ctrl_pkg::*;
(
   input  logic             clock,
   input  logic             reset_n,
   input  logic [IDX_W-1:0] rd_idx,
   output ICACHE_LINE       rd_line,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic [63:0]      wr_data,
   input  logic             invalidate_all
);
   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0]     tags  [NUM_LINES];
   logic [63:0]          lines [NUM_LINES];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         valid <= '0;
      else if (invalidate_all)
         valid <= '0;
      else if (wr_en)
         valid[wr_idx] <= 1'b1;
   end

   // Tags and data are deliberately left unreset; valid gates every use.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         tags[wr_idx]  <= wr_tag;
         lines[wr_idx] <= wr_data;
      end
   end

   always_comb begin
      rd_line       = '0;
      rd_line.valid = valid[rd_idx];
      rd_line.tag   = tags[rd_idx];
      rd_line.data  = lines[rd_idx];
   end
endmodule

// File: rtl/icache_ctrl.sv
// Instruction-cache responder: same-cycle hits, single outstanding miss to memory.
//  state   | meaning
//  IC_IDLE | no miss outstanding; a miss on the current address is captured
//  IC_REQ  | BUS_LOAD presented for miss_addr until granted with a nonzero tag
//  IC_WAIT | waiting for mem2proc_tag to match mem_tag, then fill
module icache_ctrl
   import icache_ctrl_pkg::*;
(
   input  logic         clock,
   input  logic         reset_n,
   icache_ctrl_if.slave bus
);
   ICACHE_STATE          state;
   BUS_COMMAND           command;
   logic [XLEN-1:0]      miss_addr;
   logic [MEM_TAG_W-1:0] mem_tag;
   logic                 squash;
   ICACHE_LINE           rd_line;
   logic [IDX_W-1:0]     cur_idx;
   logic [TAG_W-1:0]     cur_tag;
   logic                 hit;
   logic                 fill;
   logic                 fill_write;
   logic                 forward;

   assign cur_idx = bus.proc2Icache_addr[3 +: IDX_W];
   assign cur_tag = bus.proc2Icache_addr[XLEN-1 -: TAG_W];

   icache_line_array u_lines (
      .clock          (clock),
      .reset_n        (reset_n),
      .rd_idx         (cur_idx),
      .rd_line        (rd_line),
      .wr_en          (fill_write),
      .wr_idx         (miss_addr[3 +: IDX_W]),
      .wr_tag         (miss_addr[XLEN-1 -: TAG_W]),
      .wr_data        (bus.mem2proc_data),
      .invalidate_all (bus.invalidate_all)
   );

   assign hit        = rd_line.valid && (rd_line.tag == cur_tag);
   assign fill       = (state == IC_WAIT) && (mem_tag != '0) && (bus.mem2proc_tag == mem_tag);
   // A flush seen during the miss, or coincident with the fill, discards the fill.
   assign fill_write = fill && !squash && !bus.invalidate_all;
   assign forward    = fill_write && (bus.proc2Icache_addr[XLEN-1:3] == miss_addr[XLEN-1:3]);

   always_comb begin
      bus.Icache2proc_data_valid = hit || forward;
      bus.Icache2proc_data       = '0;
      if (hit)
         bus.Icache2proc_data = rd_line.data;
      else if (forward)
         bus.Icache2proc_data = bus.mem2proc_data;
   end

   assign bus.proc2mem_command = command;
   assign bus.proc2mem_addr    = miss_addr;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IC_IDLE;
         command   <= BUS_NONE;
         miss_addr <= '0;
         mem_tag   <= '0;
         squash    <= 1'b0;
      end else begin
         case (state)
            IC_IDLE: begin
               if (!hit) begin
                  miss_addr <= {bus.proc2Icache_addr[XLEN-1:3], 3'b000};
                  command   <= BUS_LOAD;
                  state     <= IC_REQ;
               end
            end
            IC_REQ: begin
               squash <= squash | bus.invalidate_all;
               if (bus.mem_grant && (bus.mem2proc_response != '0)) begin
                  mem_tag <= bus.mem2proc_response;
                  command <= BUS_NONE;
                  state   <= IC_WAIT;
               end
            end
            IC_WAIT: begin
               if (fill) begin
                  squash <= 1'b0;
                  state  <= IC_IDLE;
               end else begin
                  squash <= squash | bus.invalidate_all;
               end
            end
            default: begin
               command <= BUS_NONE;
               state   <= IC_IDLE;
            end
         endcase
      end
   end
endmodule
